// File: rtl/latch_handshake_reader_pkg.sv
// rtl/latch_handshake_reader_pkg.sv - shared types and constants for the latch handshake reader
package latch_handshake_reader_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int SYNC_STAGES_MIN     = 2;

endpackage

// File: rtl/latch_handshake_reader_bit_synchronizer.sv
// rtl/latch_handshake_reader_bit_synchronizer.sv - multi-flop single-bit clock-domain synchronizer
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // shift the asynchronous bit through the flop chain; oldest sample exits at the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/latch_handshake_reader.sv
// rtl/latch_handshake_reader.sv - clocked receiver for a latch-held 4-phase req/ack writer
module latch_handshake_reader
    import latch_handshake_reader_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_async,
    input  logic [WIDTH-1:0]     data_async,
    output logic                 ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0] word_count
);

    state_t state;
    state_t state_next;
    logic   req_s;
    logic   slot_free;
    logic   capture;
    logic   ack_next;

    // only the synchronized copy of the request is ever used by logic
    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_async),
        .q   (req_s)
    );

    // a new word may land when the slot is empty or is being drained this cycle
    assign slot_free = !out_valid || out_ready;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state, capture strobe and ack level; backpressure holds the writer in IDLE
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        ack_next   = ack;
        case (state)
            IDLE: begin
                ack_next = 1'b0;
                if (req_s && slot_free) begin
                    capture    = 1'b1;
                    ack_next   = 1'b1;
                    state_next = ACKED;
                end
            end
            ACKED: begin
                ack_next = 1'b1;
                if (!req_s) begin
                    ack_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                ack_next   = 1'b0;
            end
        endcase
    end

    // registered acknowledge back to the writer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0;
        end else begin
            ack <= ack_next;
        end
    end

    // capture register: latched data is sampled only in the capture cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (capture) begin
            out_data <= data_async;
        end
    end

    // valid tracking; capture wins over consume so back-to-back words have no bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // free-running count of captured words, wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (capture) begin
            word_count <= word_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_latch_handshake_reader.sv
// tb/tb_latch_handshake_reader.sv - directed self-checking bench for latch_handshake_reader
module tb_latch_handshake_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_async = 1'b0;
    logic [7:0]  data_async = 8'h00;
    logic        out_ready = 1'b0;
    logic        ack, out_valid;
    logic [7:0]  out_data;
    logic [15:0] word_count;
    logic        ack_s, out_valid_s;
    logic [7:0]  out_data_s;
    logic [3:0]  word_count_s;

    int n_checks = 0;
    int n_fail   = 0;
    logic       rand_en = 1'b0;
    logic       mon_en  = 1'b0;
    logic [7:0] got_q[$];

    latch_handshake_reader #(.WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_async  (req_async),
        .data_async (data_async),
        .ack        (ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count)
    );

    latch_handshake_reader #(.WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(4)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .req_async  (req_async),
        .data_async (data_async),
        .ack        (ack_s),
        .out_valid  (out_valid_s),
        .out_ready  (out_ready),
        .out_data   (out_data_s),
        .word_count (word_count_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rand_en) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] d);
        int t;
        data_async = d;
        req_async  = 1'b1;
        t = 0;
        while (!ack && t < 60) begin step(1); t++; end
        if (!ack) chk("xfer_ack_rise_timeout", 32'(ack), 32'd1);
        req_async = 1'b0;
        t = 0;
        while (ack && t < 60) begin step(1); t++; end
        if (ack) chk("xfer_ack_fall_timeout", 32'(ack), 32'd0);
    endtask

    initial begin
        int stuck_drop;
        int t;

        // reset state, observed while reset is held
        #12;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // basic transfer: request raised just after edge 0
        out_ready = 1'b1;
        step(1);
        data_async = 8'hA5;
        req_async  = 1'b1;
        step(2);
        chk("basic_ack_edge2", 32'(ack), 32'd0);
        step(1);
        chk("basic_ack_edge3", 32'(ack), 32'd1);
        chk("basic_valid_edge3", 32'(out_valid), 32'd1);
        chk("basic_data", 32'(out_data), 32'hA5);
        chk("basic_count", 32'(word_count), 32'd1);
        req_async = 1'b0;
        step(2);
        chk("basic_ack_hold_edge2", 32'(ack), 32'd1);
        step(1);
        chk("basic_ack_fall_edge3", 32'(ack), 32'd0);
        chk("basic_valid_consumed", 32'(out_valid), 32'd0);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        xfer(8'h11);
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        chk("bp_first_data", 32'(out_data), 32'h11);
        data_async = 8'h22;
        req_async  = 1'b1;
        step(10);
        chk("bp_second_no_ack", 32'(ack), 32'd0);
        chk("bp_data_held", 32'(out_data), 32'h11);
        chk("bp_count_held", 32'(word_count), 32'd1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("bp_capture_ack", 32'(ack), 32'd1);
        chk("bp_zero_bubble_valid", 32'(out_valid), 32'd1);
        chk("bp_second_data", 32'(out_data), 32'h22);
        chk("bp_count", 32'(word_count), 32'd2);
        req_async = 1'b0;
        step(4);
        chk("bp_ack_released", 32'(ack), 32'd0);

        // streaming with random ready
        do_reset();
        got_q.delete();
        mon_en  = 1'b1;
        rand_en = 1'b1;
        for (int i = 0; i < 20; i++) xfer(8'h30 + 8'(i));
        rand_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        step(4);
        mon_en = 1'b0;
        chk("stream_count", 32'(word_count), 32'd20);
        chk("stream_num_words", 32'(got_q.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < got_q.size()) chk($sformatf("stream_word_%0d", i), 32'(got_q[i]), 32'h30 + 32'(i));
        end

        // counter wrap on the 4-bit counter instance
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            xfer(8'(i));
            if (i == 15) chk("wrap_15", 32'(word_count_s), 32'd15);
            if (i == 16) chk("wrap_0", 32'(word_count_s), 32'd0);
            if (i == 17) chk("wrap_1", 32'(word_count_s), 32'd1);
        end
        chk("wrap_wide_count", 32'(word_count), 32'd17);

        // reset mid-transfer, request still high across release
        do_reset();
        out_ready  = 1'b0;
        data_async = 8'h5A;
        req_async  = 1'b1;
        t = 0;
        while (!ack && t < 20) begin step(1); t++; end
        chk("midrst_reached_acked", 32'(ack), 32'd1);
        chk("midrst_valid_before", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ack_now", 32'(ack), 32'd0);
        chk("midrst_valid_now", 32'(out_valid), 32'd0);
        chk("midrst_data_now", 32'(out_data), 32'd0);
        chk("midrst_count_now", 32'(word_count), 32'd0);
        step(2);
        rst = 1'b0;
        step(2);
        chk("midrst_recap_edge2", 32'(ack), 32'd0);
        step(1);
        chk("midrst_recap_edge3", 32'(ack), 32'd1);
        chk("midrst_recap_data", 32'(out_data), 32'h5A);
        chk("midrst_recap_count", 32'(word_count), 32'd1);
        req_async = 1'b0;
        step(4);

        // stuck request
        do_reset();
        out_ready  = 1'b1;
        data_async = 8'h77;
        req_async  = 1'b1;
        step(3);
        chk("stuck_first_ack", 32'(ack), 32'd1);
        stuck_drop = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (!ack) stuck_drop++;
        end
        chk("stuck_ack_never_drops", 32'(stuck_drop), 32'd0);
        chk("stuck_count", 32'(word_count), 32'd1);
        chk("stuck_data", 32'(out_data), 32'h77);
        chk("stuck_valid_consumed", 32'(out_valid), 32'd0);
        req_async = 1'b0;
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/latch_handshake_reader.md
Name: latch_handshake_reader

Overview:
- Clocked receive end of a 4-phase req/ack interface whose writer holds data in level-sensitive latches and raises `req_async` when the data is stable.
- The block synchronizes `req_async` into the `clk` domain and captures the latched word.
- It acknowledges the writer and presents the word downstream on a valid/ready output.
- It is the boundary cell between latch-held data and flip-flop pipelines.

Parameters:
- WIDTH, 8, data word width in bits.
- SYNC_STAGES, 2, flip-flop stages in the `req_async` synchronizer; legal range 2..4.
- CNT_WIDTH, 16, width of the captured-word counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_async  input  1  writer request; asynchronous to `clk`.
- data_async  input  WIDTH  latch-held writer data; stable from `req_async` rise until `ack` is seen high.
- ack  output  1  acknowledge to writer; registered.
- out_valid  output  1  `out_data` holds an unconsumed word.
- out_ready  input  1  downstream accepts the word when both `out_valid` and `out_ready` are 1.
- out_data  output  WIDTH  captured word; registered.
- word_count  output  CNT_WIDTH  number of words captured since reset; wraps.

Behaviour:
- Reset (async assert, sync release):
  - All synchronizer flops = 0, `state` = IDLE.
  - `ack` = 0, `out_valid` = 0, `out_data` = 0, `word_count` = 0.
  - Outputs go to these values immediately on `rst` rising, with no clock edge required.
- Synchronizer: `req_async` passes through SYNC_STAGES flops; the last stage is `req_s`. No other logic reads `req_async`.
- `data_async` is sampled only in the capture cycle; the writer protocol guarantees it is stable then. It is never synchronized bit-wise.
- Output slot free = (`out_valid` == 0) or (`out_ready` == 1) in the current cycle.
- State IDLE, with `ack` = 0:
  - If `req_s` == 1 and the slot is free: `out_data` <= `data_async`, `out_valid` <= 1, `ack` <= 1, `word_count` <= `word_count` + 1 (mod 2^CNT_WIDTH), go to ACKED.
  - If `req_s` == 1 and the slot is not free: stay in IDLE with `ack` = 0 (backpressure stalls the writer).
- State ACKED, with `ack` = 1:
  - Wait for `req_s` == 0, then `ack` <= 0 and go to IDLE.
  - No capture occurs in ACKED.
- Output handshake, independent of state:
  - If `out_valid` && `out_ready` and no capture this cycle, `out_valid` <= 0.
  - Capture and consume in the same cycle leaves `out_valid` = 1 with the new word (zero-bubble).
  - `out_data` changes only on capture.
- Latency:
  - `req_async` rising (setup met before edge 0) -> `ack` and `out_valid` high after edge SYNC_STAGES+1, assuming the slot is free.
  - `req_async` falling -> `ack` low after edge SYNC_STAGES+1.
  - Minimum full 4-phase cycle: 2*(SYNC_STAGES+1) clocks plus writer turnaround.
- Boundaries:
  - Word counter wraps from 2^CNT_WIDTH-1 to 0, with no flag.
  - `req_async` glitch shorter than one clock: it may or may not be captured. Writer protocol forbids this; the block does not detect it.
  - `req_async` held high forever: exactly one capture, then the block stays in ACKED.
  - `out_ready` held 0: at most one word is captured; the next request waits in IDLE with `ack` = 0.
  - Reset mid-transfer:
    - `ack` drops at once and any pending word is discarded.
    - If `req_async` is still high after release, it is treated as a new request and re-captured (duplicate permitted, documented).
  - `out_ready` is ignored while `out_valid` = 0.

Decomposition:
- Shared package:
  - `state_t` enum {IDLE, ACKED}.
  - `SYNC_STAGES_DEFAULT` = 2 and `SYNC_STAGES_MIN` = 2.
- One sub-module: `bit_synchronizer` (parameter STAGES; ports clk, rst, d, q). It is a chain of async-reset flops, reset value 0, and is reused by other clock-crossing blocks.
- Top-level contents: FSM, capture register, output valid logic, counter.

Test Plan:
- Basic transfer:
  - Stimulus: reset, `out_ready` = 1, `data_async` = 8'hA5, `req_async` rises at edge 0, drops when `ack` = 1.
  - Response: `ack` and `out_valid` go high after edge 3; `out_data` = 8'hA5; `word_count` = 1; `ack` goes low 3 edges after `req_async` falls.
- Backpressure:
  - Stimulus: `out_ready` = 0; the writer sends 8'h11, then 8'h22.
  - Response: 8'h11 held with `out_valid` = 1; the second request gets no `ack` while `out_ready` = 0. After `out_ready` pulses 1 for one cycle, 8'h22 is captured in that same cycle and `out_valid` stays 1.
- Streaming:
  - Stimulus: 20 back-to-back 4-phase transfers with incrementing data, `out_ready` random at 50%.
  - Response: all 20 words appear in order with no duplicates or losses; `word_count` = 20.
- Counter wrap:
  - Stimulus: CNT_WIDTH = 4, 17 transfers.
  - Response: `word_count` reads 15, then 0, then 1.
- Reset mid-operation:
  - Stimulus: assert `rst` while in ACKED with `out_valid` = 1, between clock edges.
  - Response: `ack`, `out_valid` and `out_data` go to 0 immediately. With `req_async` still 1 at release, a recapture occurs after SYNC_STAGES+1 edges.
- Stuck request:
  - Stimulus: hold `req_async` = 1 for 50 cycles, `out_ready` = 1.
  - Response: exactly one capture and `word_count` = 1; `ack` stays 1 throughout.
